// File: rtl/cnn_obi_ctrl_regs_pkg.sv
// cnn_pkg: register map, CTRL/STATUS bit positions, job FSM states and a byte-enable merge helper
package cnn_pkg;
  localparam logic [7:0] CNN_REG_CTRL     = 8'h00;
  localparam logic [7:0] CNN_REG_STATUS   = 8'h04;
  localparam logic [7:0] CNN_REG_IN_BASE  = 8'h08;
  localparam logic [7:0] CNN_REG_OUT_BASE = 8'h0C;
  localparam logic [7:0] CNN_REG_WGT_BASE = 8'h10;
  localparam logic [7:0] CNN_REG_LEN      = 8'h14;
  localparam logic [7:0] CNN_REG_CYCLES   = 8'h18;
  localparam logic [7:0] CNN_REG_RSVD     = 8'h1C;
  localparam int CNN_CTRL_START   = 0;
  localparam int CNN_CTRL_IRQ_EN  = 1;
  localparam int CNN_STATUS_BUSY  = 0;
  localparam int CNN_STATUS_DONE  = 1;
  typedef enum logic [1:0] {CNN_IDLE, CNN_RUN, CNN_DONE} cnn_ctrl_state_e;
  function automatic logic [31:0] cnn_be_merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                               input logic [3:0] be);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i+:8] = be[i] ? new_v[8*i+:8] : old_v[8*i+:8];
    return m;
  endfunction
endpackage

// File: rtl/cnn_obi_ctrl_regs_if.sv
// cnn_obi_ctrl_regs_if: OBI request/response bundle between host master and the control register block
interface cnn_obi_ctrl_regs_if #(
  parameter int AddrWidth = 32,
  parameter int DataWidth = 32
);
  logic                   req;
  logic                   gnt;
  logic [AddrWidth-1:0]   addr;
  logic                   we;
  logic [DataWidth/8-1:0] be;
  logic [DataWidth-1:0]   wdata;
  logic                   rvalid;
  logic [DataWidth-1:0]   rdata;
  logic                   err;
  modport master (output req, addr, we, be, wdata, input gnt, rvalid, rdata, err);
  modport slave  (input req, addr, we, be, wdata, output gnt, rvalid, rdata, err);
endinterface

// File: rtl/cnn_obi_ctrl_regs.sv
// cnn_obi_ctrl_regs: OBI control/status registers for the CNN core (job FSM, start pulse, level irq);
// define CNN_PERF_CNT_EN to add the read-only RUN cycle counter at offset 0x18
module cnn_obi_ctrl_regs
  import cnn_pkg::*;
#(
  parameter int AddrWidth = 32,
  parameter int DataWidth = 32,
  parameter int RegAw     = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  cnn_obi_ctrl_regs_if.slave    obi,
  output logic                  start_o,
  input  logic                  core_done_i,
  output logic [DataWidth-1:0]  in_base_o,
  output logic [DataWidth-1:0]  out_base_o,
  output logic [DataWidth-1:0]  wgt_base_o,
  output logic [15:0]           len_o,
  output logic                  irq_o
);
  cnn_ctrl_state_e      r_state;
  logic                 r_irq_en;
  logic [DataWidth-1:0] r_in_base;
  logic [DataWidth-1:0] r_out_base;
  logic [DataWidth-1:0] r_wgt_base;
  logic [15:0]          r_len;
  logic                 r_rvalid;
  logic                 r_err;
  logic [DataWidth-1:0] r_rdata;
  logic                 r_start;
`ifdef CNN_PERF_CNT_EN
  logic [31:0]          r_cycles;
`endif
  logic [7:0]           w_off;
  logic                 w_run;
  logic                 w_done;
  logic                 w_start_wr;
  logic                 w_err;
  logic [DataWidth-1:0] w_rd;
  logic                 w_wr;
  logic                 w_go;
  logic                 w_clr;
  logic                 w_unused;
  assign w_off      = 8'({obi.addr[RegAw+1:2], 2'b00});
  assign w_run      = r_state == CNN_RUN;
  assign w_done     = r_state == CNN_DONE;
  assign w_start_wr = obi.be[0] & obi.wdata[CNN_CTRL_START];
  assign w_wr       = obi.req & obi.we & ~w_err;
  assign w_go       = w_wr & (w_off == CNN_REG_CTRL) & w_start_wr;
  assign w_clr      = w_wr & (w_off == CNN_REG_STATUS) & obi.be[0] & obi.wdata[CNN_STATUS_DONE];
  assign w_unused   = ^{obi.addr[AddrWidth-1:RegAw+2], obi.addr[1:0]};
  // Address decode: read mux and error classification for the current request
  always_comb begin
    w_err = 1'b0;
    w_rd  = '0;
    case (w_off)
      CNN_REG_CTRL: begin
        w_rd[CNN_CTRL_IRQ_EN] = r_irq_en;
        w_err = obi.we & w_run & w_start_wr;
      end
      CNN_REG_STATUS: begin
        w_rd[CNN_STATUS_BUSY] = w_run;
        w_rd[CNN_STATUS_DONE] = w_done;
      end
      CNN_REG_IN_BASE:  begin w_rd = r_in_base;  w_err = obi.we & w_run; end
      CNN_REG_OUT_BASE: begin w_rd = r_out_base; w_err = obi.we & w_run; end
      CNN_REG_WGT_BASE: begin w_rd = r_wgt_base; w_err = obi.we & w_run; end
      CNN_REG_LEN:      begin w_rd = DataWidth'(r_len); w_err = obi.we & w_run; end
`ifdef CNN_PERF_CNT_EN
      CNN_REG_CYCLES:   begin w_rd = r_cycles; w_err = obi.we; end
`endif
      default: w_err = 1'b1;
    endcase
  end
  // Response stage: every accepted request answers exactly one cycle later
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_rvalid <= obi.req;
      r_err    <= obi.req & w_err;
      r_rdata  <= (obi.req & ~obi.we & ~w_err) ? w_rd : '0;
    end
  end
  // Configuration registers with per-byte write enables
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_irq_en   <= 1'b0;
      r_in_base  <= '0;
      r_out_base <= '0;
      r_wgt_base <= '0;
      r_len      <= '0;
    end else begin
      if (w_wr && w_off == CNN_REG_CTRL && obi.be[0]) r_irq_en <= obi.wdata[CNN_CTRL_IRQ_EN];
      if (w_wr && w_off == CNN_REG_IN_BASE)  r_in_base  <= cnn_be_merge(r_in_base, obi.wdata, obi.be);
      if (w_wr && w_off == CNN_REG_OUT_BASE) r_out_base <= cnn_be_merge(r_out_base, obi.wdata, obi.be);
      if (w_wr && w_off == CNN_REG_WGT_BASE) r_wgt_base <= cnn_be_merge(r_wgt_base, obi.wdata, obi.be);
      if (w_wr && w_off == CNN_REG_LEN)
        r_len <= {obi.be[1] ? obi.wdata[15:8] : r_len[15:8], obi.be[0] ? obi.wdata[7:0] : r_len[7:0]};
    end
  end
  // Job FSM; a completion in RUN beats a simultaneous W1C, and done is simply the DONE state
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= CNN_IDLE;
      r_start <= 1'b0;
    end else begin
      r_start <= w_go;
      r_state <= w_go ? CNN_RUN : (w_run & core_done_i) ? CNN_DONE : (w_done & w_clr) ? CNN_IDLE : r_state;
    end
  end
`ifdef CNN_PERF_CNT_EN
  // Saturating count of cycles spent in RUN, restarted on each job launch
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_cycles <= '0;
    else if (w_go) r_cycles <= '0;
    else if (w_run && r_cycles != '1) r_cycles <= r_cycles + 32'd1;
  end
`endif
  assign obi.gnt    = 1'b1;
  assign obi.rvalid = r_rvalid;
  assign obi.err    = r_err;
  assign obi.rdata  = r_rdata;
  assign start_o    = r_start;
  assign in_base_o  = r_in_base;
  assign out_base_o = r_out_base;
  assign wgt_base_o = r_wgt_base;
  assign len_o      = r_len;
  assign irq_o      = w_done & r_irq_en;
endmodule

// File: tb/tb_cnn_obi_ctrl_regs.sv
// tb_cnn_obi_ctrl_regs: directed OBI transactions against a register-map level model, checked every cycle
module tb_cnn_obi_ctrl_regs;
  localparam bit PERF =
`ifdef CNN_PERF_CNT_EN
    1'b1;
`else
    1'b0;
`endif
  logic        clk = 1'b0;
  logic        rst_ni;
  logic        core_done;
  logic        start_o;
  logic [31:0] in_base_o, out_base_o, wgt_base_o;
  logic [15:0] len_o;
  logic        irq_o;
  int          n_vec = 0;
  int          n_bad = 0;
  logic        chk_on;
  logic [31:0] rd;
  logic        er;
  logic [31:0] m_reg [8];
  int          m_phase;
  longint      m_cyc;
  logic        e_rvalid, e_err, e_start;
  logic [31:0] e_rdata;
  cnn_obi_ctrl_regs_if bus ();
  cnn_obi_ctrl_regs dut (
    .clk_i(clk), .rst_ni(rst_ni), .obi(bus), .start_o(start_o), .core_done_i(core_done),
    .in_base_o(in_base_o), .out_base_o(out_base_o), .wgt_base_o(wgt_base_o), .len_o(len_o), .irq_o(irq_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [31:0] rd_val(input int w);
    case (w)
      0: return m_reg[0] & 32'h2;
      1: return {30'b0, m_phase == 2, m_phase == 1};
      6: return 32'(m_cyc);
      default: return m_reg[w];
    endcase
  endfunction
  // Model: phase 0 idle, 1 running, 2 finished; m_reg holds each word's architectural value
  always @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < 8; k++) m_reg[k] = '0;
      m_phase = 0; m_cyc = 0;
      e_rvalid = 0; e_err = 0; e_rdata = '0; e_start = 0;
    end else begin
      bit busy, go, ok;
      int w;
      logic [31:0] mask, nv;
      busy = m_phase == 1; go = 0;
      e_rvalid = bus.req; e_err = 0; e_rdata = '0;
      if (bus.req) begin
        w = int'(bus.addr[4:2]);
        ok = (w <= 5) || (PERF && w == 6);
        mask = {{8{bus.be[3]}}, {8{bus.be[2]}}, {8{bus.be[1]}}, {8{bus.be[0]}}};
        if (!bus.we) begin
          if (!ok) e_err = 1; else e_rdata = rd_val(w);
        end else if (!ok || w == 6 || (busy && (w >= 2 || (w == 0 && bus.be[0] && bus.wdata[0])))) begin
          e_err = 1;
        end else begin
          nv = (m_reg[w] & ~mask) | (bus.wdata & mask);
          if (w == 0) begin
            if (bus.be[0]) begin m_reg[0] = bus.wdata & 32'h2; go = bus.wdata[0]; end
          end else if (w == 1) begin
            if (bus.be[0] && bus.wdata[1] && m_phase == 2) m_phase = 0;
          end else m_reg[w] = (w == 5) ? (nv & 32'hFFFF) : nv;
        end
      end
      if (busy && core_done) m_phase = 2;
      if (go) begin m_phase = 1; m_cyc = 0; end
      else if (busy && m_cyc < 64'hFFFF_FFFF) m_cyc++;
      e_start = go;
    end
  end
  // Compare process: DUT outputs against the model on every falling edge
  always @(negedge clk) if (chk_on) begin
    chk("rvalid", 32'(bus.rvalid), 32'(e_rvalid));
    if (e_rvalid) begin
      chk("rdata", bus.rdata, e_rdata);
      chk("err", 32'(bus.err), 32'(e_err));
    end
    chk("gnt", 32'(bus.gnt), 32'd1);
    chk("start", 32'(start_o), 32'(e_start));
    chk("in_base", in_base_o, m_reg[2]);
    chk("out_base", out_base_o, m_reg[3]);
    chk("wgt_base", wgt_base_o, m_reg[4]);
    chk("len", 32'(len_o), m_reg[5]);
    chk("irq", 32'(irq_o), 32'(m_phase == 2 && m_reg[0][1]));
  end
  // One transaction, called just after a rising edge; returns just after the response edge
  task automatic xfer(input logic [31:0] a, input logic we, input logic [3:0] be, input logic [31:0] wd,
                      output logic [31:0] r, output logic e);
    bus.req = 1; bus.addr = a; bus.we = we; bus.be = be; bus.wdata = wd;
    @(posedge clk); #1;
    bus.req = 0;
    chk("xfer_rvalid", 32'(bus.rvalid), 32'd1);
    r = bus.rdata; e = bus.err;
  endtask
  logic [31:0] b2b_a [3] = '{32'h08, 32'h0C, 32'h14};
  logic [31:0] b2b_d [3] = '{32'h1000_0000, 32'h2000_0000, 32'h0000_0040};
  initial begin
    bus.req = 0; bus.addr = '0; bus.we = 0; bus.be = '0; bus.wdata = '0;
    core_done = 0; rst_ni = 0; chk_on = 0;
    repeat (2) @(posedge clk);
    #1 rst_ni = 1; chk_on = 1;
    xfer(32'h04, 0, 4'hF, 0, rd, er);
    chk("rst_status", rd, 32'h0); chk("rst_status_err", 32'(er), 32'd0); chk("rst_irq", 32'(irq_o), 32'd0);
    xfer(32'h1C, 0, 4'hF, 0, rd, er);
    chk("rsvd_err", 32'(er), 32'd1); chk("rsvd_rdata", rd, 32'h0);
    for (int i = 0; i < 3; i++) begin
      bus.req = 1; bus.we = 1; bus.be = 4'hF; bus.addr = b2b_a[i]; bus.wdata = b2b_d[i];
      @(posedge clk); #1;
      chk("b2b_rvalid", 32'(bus.rvalid), 32'd1);
    end
    bus.req = 0;
    chk("b2b_in", in_base_o, 32'h1000_0000); chk("b2b_out", out_base_o, 32'h2000_0000);
    chk("b2b_len", 32'(len_o), 32'h40);
    xfer(32'h10, 1, 4'b0011, 32'hDEAD_BEEF, rd, er);
    chk("be_wgt", wgt_base_o, 32'h0000_BEEF);
    xfer(32'h00, 1, 4'hF, 32'h3, rd, er);
    chk("start_hi", 32'(start_o), 32'd1);
    xfer(32'h08, 1, 4'hF, 32'h5555_5555, rd, er);
    chk("start_lo", 32'(start_o), 32'd0);
    chk("run_wr_err", 32'(er), 32'd1); chk("run_wr_kept", in_base_o, 32'h1000_0000);
    xfer(32'h04, 0, 4'hF, 0, rd, er);
    chk("busy", rd, 32'h1);
    repeat (22) @(posedge clk);
    #1 core_done = 1;
    @(posedge clk); #1 core_done = 0;
    xfer(32'h04, 0, 4'hF, 0, rd, er);
    chk("done_status", rd, 32'h2); chk("done_irq", 32'(irq_o), 32'd1);
    xfer(32'h18, 0, 4'hF, 0, rd, er);
    if (PERF) chk("cycles", rd, 32'd25);
    else chk("cycles_err", 32'(er), 32'd1);
    xfer(32'h04, 1, 4'hF, 32'h2, rd, er);
    chk("w1c_irq", 32'(irq_o), 32'd0);
    xfer(32'h04, 0, 4'hF, 0, rd, er);
    chk("w1c_status", rd, 32'h0);
    xfer(32'h08, 1, 4'h0, 32'hFFFF_FFFF, rd, er);
    chk("be0_err", 32'(er), 32'd0); chk("be0_kept", in_base_o, 32'h1000_0000);
    xfer(32'h1000_0008, 0, 4'hF, 0, rd, er);
    chk("alias_rd", rd, 32'h1000_0000);
    xfer(32'h00, 1, 4'hF, 32'h3, rd, er);
    bus.req = 1; bus.we = 1; bus.be = 4'hF; bus.addr = 32'h04; bus.wdata = 32'h2; core_done = 1;
    @(posedge clk); #1 bus.req = 0; core_done = 0;
    chk("sim_err", 32'(bus.err), 32'd0);
    xfer(32'h04, 0, 4'hF, 0, rd, er);
    chk("sim_status", rd, 32'h2); chk("sim_irq", 32'(irq_o), 32'd1);
    xfer(32'h00, 1, 4'hF, 32'h1, rd, er);
    xfer(32'h04, 0, 4'hF, 0, rd, er);
    chk("restart_status", rd, 32'h1); chk("restart_irq", 32'(irq_o), 32'd0);
    bus.req = 1; bus.we = 0; bus.addr = 32'h04;
    @(posedge clk); #1 bus.req = 0;
    chk("inflight_rvalid", 32'(bus.rvalid), 32'd1);
    #2 rst_ni = 0;
    #1;
    chk("rst_drop", 32'(bus.rvalid), 32'd0); chk("rst_start", 32'(start_o), 32'd0);
    chk("rst_irq2", 32'(irq_o), 32'd0); chk("rst_in", in_base_o, 32'h0);
    @(posedge clk); #1 rst_ni = 1;
    xfer(32'h04, 0, 4'hF, 0, rd, er);
    chk("rst_run_status", rd, 32'h0);
    repeat (2) @(posedge clk);
    #1 chk_on = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
